// File: rtl/seq_booth_multiplier.sv
// -----------------------------------------------------------------------------
// seq_booth_multiplier
//   Multi-cycle radix-4 Booth multiplier for the MUL instruction. Operands are
//   latched on an accepted start; the product is built one radix-4 digit per
//   clock and presented as hi/lo (2*WIDTH bits). Handles signed (two's
//   complement) and unsigned operands. Latency is fixed at WIDTH/2+1 clocks.
//
// Ports
//   clk          in   1      rising-edge clock
//   clr          in   1      synchronous active-low reset (any state)
//   start        in   1      request, accepted only in IDLE or DONE
//   signed_mode  in   1      1 = signed operands, 0 = unsigned (with start)
//   a            in   WIDTH  multiplicand (sampled with start)
//   b            in   WIDTH  multiplier   (sampled with start)
//   busy         out  1      high while iterating
//   done         out  1      one-cycle pulse, hi/lo freshly valid
//   hi           out  WIDTH  upper half of product (held until next done)
//   lo           out  WIDTH  lower half of product (held until next done)
//   ovf          out  1      only with MUL_OVF_EN: product does not fit WIDTH
//
// Configuration macro: MUL_OVF_EN adds the ovf port and its logic.
// -----------------------------------------------------------------------------
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
`ifdef MUL_OVF_EN
    output logic [WIDTH-1:0] lo,
    output logic             ovf
`else
    output logic [WIDTH-1:0] lo
`endif
);

    localparam int ITER  = WIDTH / 2 + 1;
    localparam int EXT_W = WIDTH + 2;          // extended operand width
    localparam int P_W   = EXT_W + 2;          // upper accumulator: room for +/-2M
    localparam int ACC_W = P_W + EXT_W + 1;    // {P, multiplier, Booth bit}
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

    state_t                   state, state_next;
    logic signed [P_W-1:0]    mcand;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_step;
    logic signed [P_W-1:0]    p_sum;
    logic [CNT_W-1:0]         cnt;
    logic                     accept;
    logic                     last;
    logic                     ext_a;
    logic                     ext_b;
`ifdef MUL_OVF_EN
    logic                     sgn;
    logic                     ovf_next;
`endif

    // Booth digit {-2,-1,0,+1,+2} applied to the multiplicand.
    function automatic logic signed [P_W-1:0] booth_addend(
        input logic [2:0]            trip,
        input logic signed [P_W-1:0] m
    );
        case (trip)
            3'b001, 3'b010: return m;
            3'b011:         return m <<< 1;
            3'b100:         return -(m <<< 1);
            3'b101, 3'b110: return -m;
            default:        return '0;
        endcase
    endfunction

    assign accept = start && (state == IDLE || state == DONE_ST);
    assign last   = (state == RUN) && (cnt == '0);
    assign ext_a  = signed_mode & a[WIDTH-1];
    assign ext_b  = signed_mode & b[WIDTH-1];

    // One radix-4 step: add digit*M into the upper part, then shift right by 2.
    // After ITER steps the full product sits at acc[..:1]; bit 0 is a spent
    // multiplier bit.
    always_comb begin
        p_sum    = acc[ACC_W-1 -: P_W] + booth_addend(acc[2:0], mcand);
        acc_step = $signed({p_sum, acc[EXT_W:0]}) >>> 2;
    end

`ifdef MUL_OVF_EN
    always_comb begin
        if (sgn)
            ovf_next = (acc_step[2*WIDTH:WIDTH+1] != {WIDTH{acc_step[WIDTH]}});
        else
            ovf_next = (acc_step[2*WIDTH:WIDTH+1] != '0);
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!clr)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == '0) state_next = DONE_ST;
            DONE_ST: state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE_ST);
    end

    // Datapath: operand capture, iteration, result registers
    always_ff @(posedge clk) begin
        if (!clr) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
`ifdef MUL_OVF_EN
            sgn   <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            mcand <= {{(P_W - WIDTH){ext_a}}, a};
            acc   <= {{P_W{1'b0}}, {2{ext_b}}, b, 1'b0};
            cnt   <= CNT_W'(ITER - 1);
`ifdef MUL_OVF_EN
            sgn   <= signed_mode;
`endif
        end else if (state == RUN) begin
            acc <= acc_step;
            cnt <= cnt - CNT_W'(1);
            if (last) begin
                hi  <= acc_step[2*WIDTH:WIDTH+1];
                lo  <= acc_step[WIDTH:1];
`ifdef MUL_OVF_EN
                ovf <= ovf_next;
`endif
            end
        end
    end

endmodule
